spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one parameter: TX_WAIT_MAX, default 15, the maximum number of cycles to wait for tx_valid, used only when SPI_SLAVE_TX_TIMEOUT_EN is defined.
REQ-002 The block SHALL have the following port: clk, input, 1 bit, single clock; all logic is on the rising edge.
REQ-003 The block SHALL have the following port: rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have the following port: SS_n, input, 1 bit, active-low slave select; low marks a frame.
REQ-005 The block SHALL have the following port: MOSI, input, 1 bit, serial data from the master, MSB first.
REQ-006 The block SHALL have the following port: MISO, output, 1 bit, serial read data to the master, MSB first.
REQ-007 The block SHALL have the following port: rx_data, output, 10 bits, deserialized word {cmd[1:0], payload[7:0]} sent to the RAM's din.
REQ-008 The block SHALL have the following port: rx_valid, output, 1 bit, one-cycle strobe qualifying rx_data.
REQ-009 The block SHALL have the following port: tx_data, input, 8 bits, read data from the RAM's dout.
REQ-010 The block SHALL have the following port: tx_valid, input, 1 bit, qualifies tx_data.

Function
REQ-011 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA, plus SEND, where the FSM stays while serializing.
REQ-012 In IDLE, sampling SS_n=0 SHALL move the FSM to CHK_CMD on the next cycle; SS_n=1 SHALL keep it in IDLE.
REQ-013 In CHK_CMD, the sampled MOSI bit SHALL be shifted in as bit 9.
- MOSI=0 SHALL move to WRITE.
- MOSI=1 with addr_rcvd=0 SHALL move to READ_ADD.
- MOSI=1 with addr_rcvd=1 SHALL move to READ_DATA.
REQ-014 WRITE, READ_ADD and READ_DATA SHALL each shift in the 9 remaining bits (bits 8..0) on 9 consecutive edges, using a 4-bit bit counter.
REQ-015 rx_data SHALL be updated and rx_valid driven high on the cycle after bit 0 is sampled, for exactly one cycle; rx_data SHALL hold its value afterwards.
REQ-016 Completing a READ_ADD frame SHALL set addr_rcvd; completing a READ_DATA transfer, meaning the last MISO bit is sent, SHALL clear it.
REQ-017 After the rx_valid strobe, WRITE and READ_ADD SHALL ignore MOSI until SS_n=1.
REQ-018 After its rx_valid strobe, READ_DATA SHALL wait for tx_valid=1.
- On the edge that samples tx_valid=1, it SHALL capture tx_data and enter SEND.
- In SEND, MISO SHALL carry tx_data[7..0] on 8 consecutive cycles, starting the cycle after capture.
REQ-019 MISO SHALL be 0 whenever the FSM is not in SEND, and after the 8th bit.
REQ-020 Raising SS_n in any state SHALL return the FSM to IDLE on the next edge.
- The counters SHALL clear.
- No rx_valid SHALL be produced for a partial frame.
- addr_rcvd SHALL be unchanged.
REQ-021 rx_data[9:8] SHALL be forwarded exactly as received; the command bits SHALL NOT be checked against the state.
REQ-022 The FSM SHALL ignore a tx_valid pulse while it is not waiting in READ_DATA.

Reset
REQ-023 While rst_n=0 is sampled, the block SHALL clear:
- FSM to IDLE;
- bit counter to 0;
- shift register to 0;
- rx_data to 0;
- rx_valid to 0;
- MISO to 0;
- addr_rcvd to 0;
- wait counter to 0.
REQ-024 Reset SHALL take priority over SS_n and abort any frame in progress; the first frame after reset SHALL start with addr_rcvd=0.

Configuration
REQ-025 The macro SPI_SLAVE_TX_TIMEOUT_EN SHALL select the tx_valid timeout.
- Defined: if tx_valid is not sampled high within TX_WAIT_MAX cycles after the rx_valid strobe in READ_DATA, the block SHALL do three things. It SHALL clear addr_rcvd, hold MISO at 0 and wait for SS_n=1.
- Undefined: READ_DATA SHALL wait for tx_valid indefinitely, with no wait counter in the RTL.

Verification
REQ-026 Reset: rst_n=0 during a frame, at bit 5 -> next cycle rx_valid=0, rx_data=0, MISO=0; the next read frame goes to READ_ADD.
REQ-027 Write address: SS_n low, MOSI 00_1010_0101 -> rx_data=0x0A5 with rx_valid high for one cycle, 11 cycles after SS_n is sampled low. Write data 01_0011_1100 -> rx_data=0x13C.
REQ-028 Read: frame 10_1010_0101 -> rx_data=0x2A5. Frame 11_xxxx_xxxx, then tx_valid=1 with tx_data=0x3C 2 cycles later -> MISO 0,0,1,1,1,1,0,0 on the following 8 cycles, and addr_rcvd cleared.
REQ-029 Abort: SS_n high after 6 bits of a write frame -> no rx_valid, FSM in IDLE on the next edge; a following full frame decodes correctly.
REQ-030 Back-to-back: two read-address frames in a row -> the second one goes to READ_DATA, because addr_rcvd=1.
REQ-031 Timeout (macro defined): no tx_valid for 15 cycles -> MISO stays 0, addr_rcvd=0; (macro undefined) tx_valid on cycle 40 still produces the correct 8 MISO bits.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM.
// Deserializes 10-bit frames {cmd[1:0], payload[7:0]} from MOSI into rx_data,
// tracks whether a read address has been delivered, and serializes the
// RAM's read data onto MISO.
// Optional feature macro: SPI_SLAVE_TX_TIMEOUT_EN abandons a read when
// tx_valid does not arrive within TX_WAIT_MAX cycles.
module spi_slave #(
    parameter int unsigned TX_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BYTE_W  = 8;

    // Bit counter encodings: 0..8 while shifting, LAST_SHIFT when the word
    // is complete, DONE after the strobe, TIMED_OUT after an abandoned read.
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(9);
    localparam logic [CNT_W-1:0] DONE       = CNT_W'(10);
    localparam logic [CNT_W-1:0] TIMED_OUT  = CNT_W'(11);
    localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(8);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        SEND      = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [FRAME_W-1:0]   shift_reg, shift_reg_nxt;
    logic [FRAME_W-1:0]   rx_data_nxt;
    logic                 rx_valid_nxt;
    logic                 miso_nxt;
    logic                 addr_rcvd, addr_rcvd_nxt;
    logic [BYTE_W-1:0]    tx_buf, tx_buf_nxt;
    logic                 tx_wait_c;

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TX_WAIT_MAX + 1);
    logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
`else
    logic                 unused_tx_wait_max;
    assign unused_tx_wait_max = ^32'(TX_WAIT_MAX);
`endif

    // READ_DATA has delivered its address word and is waiting for the RAM
    assign tx_wait_c = (state == READ_DATA) && (bit_cnt == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; deselect wins from every state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!SS_n) state_nxt = CHK_CMD;
            CHK_CMD:   state_nxt = MOSI ? (addr_rcvd ? READ_DATA : READ_ADD) : WRITE;
            READ_DATA: if (tx_wait_c && tx_valid) state_nxt = SEND;
            default:   state_nxt = state;
        endcase
        if (SS_n) begin
            state_nxt = IDLE;
        end
    end

    // Datapath next values: shifting, strobe, read-address tracking, MISO serializer
    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        shift_reg_nxt = shift_reg;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        miso_nxt      = 1'b0;
        addr_rcvd_nxt = addr_rcvd;
        tx_buf_nxt    = tx_buf;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
        wait_cnt_nxt  = '0;
`endif
        if (SS_n) begin
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_nxt = '0;
                end
                CHK_CMD: begin
                    shift_reg_nxt = {shift_reg[FRAME_W-2:0], MOSI};
                    bit_cnt_nxt   = '0;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt < LAST_SHIFT) begin
                        shift_reg_nxt = {shift_reg[FRAME_W-2:0], MOSI};
                        bit_cnt_nxt   = bit_cnt + CNT_W'(1);
                    end else if (bit_cnt == LAST_SHIFT) begin
                        rx_data_nxt  = shift_reg;
                        rx_valid_nxt = 1'b1;
                        bit_cnt_nxt  = DONE;
                        if (state == READ_ADD) begin
                            addr_rcvd_nxt = 1'b1;
                        end
                    end else if (tx_wait_c) begin
                        if (tx_valid) begin
                            miso_nxt    = tx_data[BYTE_W-1];
                            tx_buf_nxt  = {tx_data[BYTE_W-2:0], 1'b0};
                            bit_cnt_nxt = CNT_W'(1);
                        end
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
                        else if (wait_cnt == WAIT_W'(TX_WAIT_MAX - 1)) begin
                            addr_rcvd_nxt = 1'b0;
                            bit_cnt_nxt   = TIMED_OUT;
                        end else begin
                            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                        end
`endif
                    end
                end
                SEND: begin
                    if (bit_cnt < SEND_LAST) begin
                        miso_nxt    = tx_buf[BYTE_W-1];
                        tx_buf_nxt  = {tx_buf[BYTE_W-2:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end else if (bit_cnt == SEND_LAST) begin
                        addr_rcvd_nxt = 1'b0;
                        bit_cnt_nxt   = DONE;
                    end
                end
                default: begin
                    bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Datapath register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            MISO      <= 1'b0;
            addr_rcvd <= 1'b0;
            tx_buf    <= '0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_reg_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            MISO      <= miso_nxt;
            addr_rcvd <= addr_rcvd_nxt;
            tx_buf    <= tx_buf_nxt;
        end
    end

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    // Cycles spent waiting for tx_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`endif

endmodule
